// File: rtl/pcoeff_result_collector_pkg.sv
// Shared widths and state encoding for the pcoeff result collector.
// These widths stand in for the pipeline globals (PCOEFF_COUNT_BITWIDTH and its derived widths).
package pcoeff_result_collector_pkg;

    localparam int PCOEFF_COUNT_BITWIDTH = 16;
    localparam int PCOEFF_COUNT_WIDTH    = PCOEFF_COUNT_BITWIDTH + 2;
    localparam int PCOEFF_SUM_WIDTH      = PCOEFF_COUNT_BITWIDTH + 2 + 35;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } collectorState_t;

endpackage

// File: rtl/pcoeff_result_collector_resultBuffer2.sv
// resultBuffer2: two-entry in-order FIFO with a valid/ready output side and an occupancy count.
// The writer must never push when occupancy is 2; the collector's grab guard ensures that.
module resultBuffer2 #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pushValid,
    input  logic [DATA_WIDTH-1:0] pushData,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [DATA_WIDTH-1:0] outData,
    output logic [1:0]            occupancy
);

    logic [DATA_WIDTH-1:0] entry0;
    logic [DATA_WIDTH-1:0] entry1;
    logic                  rdPtr;
    logic                  wrPtr;
    logic                  pop;

    // Handshake: an entry leaves on a cycle where outValid && outReady; the head is
    // held unchanged while outValid is high and outReady is low.
    assign outValid = (occupancy != 2'd0);
    assign pop      = outValid && outReady;
    assign outData  = rdPtr ? entry1 : entry0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entry0    <= '0;
            entry1    <= '0;
            rdPtr     <= 1'b0;
            wrPtr     <= 1'b0;
            occupancy <= 2'd0;
        end else begin
            if (pushValid) begin
                if (wrPtr) entry1 <= pushData;
                else       entry0 <= pushData;
                wrPtr <= ~wrPtr;
            end
            if (pop) begin
                rdPtr <= ~rdPtr;
            end
            case ({pushValid, pop})
                2'b10:   occupancy <= occupancy + 2'd1;
                2'b01:   occupancy <= occupancy - 2'd1;
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: rtl/pcoeff_result_collector.sv
// pcoeff_result_collector: grabs results from the permutation pack, tags them and queues them in a
// two-entry valid/ready buffer. Defining PCOEFF_RESULT_CHECK_EN adds the sticky resultError check.
module pcoeff_result_collector
    import pcoeff_result_collector_pkg::*;
#(
    parameter int SUM_WIDTH    = PCOEFF_SUM_WIDTH,
    parameter int COUNT_WIDTH  = PCOEFF_COUNT_WIDTH,
    parameter int GRAB_LATENCY = 8,
    parameter int TAG_WIDTH    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   resultsAvailable,
    output logic                   grabResults,
    input  logic [SUM_WIDTH-1:0]   pcoeffSum,
    input  logic [COUNT_WIDTH-1:0] pcoeffCount,
    output logic                   outValid,
    input  logic                   outReady,
    output logic [TAG_WIDTH-1:0]   outTag,
    output logic [SUM_WIDTH-1:0]   outSum,
    output logic [COUNT_WIDTH-1:0] outCount,
    output logic [1:0]             occupancy,
`ifdef PCOEFF_RESULT_CHECK_EN
    output logic                   resultError,
`endif
    output collectorState_t        dbgState
);

    localparam int CNT_W  = $clog2(GRAB_LATENCY);
    localparam int DATA_W = TAG_WIDTH + SUM_WIDTH + COUNT_WIDTH;

    collectorState_t         state;
    collectorState_t         nextState;
    logic [CNT_W-1:0]        waitCnt;
    logic [TAG_WIDTH-1:0]    tag;
    logic                    startGrab;
    logic                    capture;
    logic                    pop;
    logic [1:0]              occAfterPop;
    logic [DATA_W-1:0]       headData;

    assign pop         = outValid && outReady;
    assign occAfterPop = occupancy - {1'b0, pop};
    assign dbgState    = state;

    // A grab is only started when the slot it will fill is already guaranteed free.
    always_comb begin
        nextState = state;
        startGrab = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (resultsAvailable && (occAfterPop < 2'd2)) begin
                    startGrab = 1'b1;
                    nextState = WAIT;
                end
            end
            WAIT: begin
                if (waitCnt == '0) begin
                    capture   = 1'b1;
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            grabResults <= 1'b0;
            waitCnt     <= '0;
            tag         <= '0;
        end else begin
            state       <= nextState;
            grabResults <= startGrab;
            if (startGrab) begin
                waitCnt <= CNT_W'(GRAB_LATENCY - 1);
            end else if (state == WAIT && waitCnt != '0) begin
                waitCnt <= waitCnt - CNT_W'(1);
            end
            if (capture) begin
                tag <= tag + TAG_WIDTH'(1);
            end
        end
    end

`ifdef PCOEFF_RESULT_CHECK_EN
    logic badResult;

    assign badResult = ((pcoeffCount == '0) && (pcoeffSum != '0)) ||
                       (pcoeffSum < SUM_WIDTH'(pcoeffCount));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resultError <= 1'b0;
        end else if (capture && badResult) begin
            resultError <= 1'b1;
        end
    end
`endif

    resultBuffer2 #(
        .DATA_WIDTH(DATA_W)
    ) u_buffer (
        .clk       (clk),
        .rst       (rst),
        .pushValid (capture),
        .pushData  ({tag, pcoeffSum, pcoeffCount}),
        .outValid  (outValid),
        .outReady  (outReady),
        .outData   (headData),
        .occupancy (occupancy)
    );

    assign {outTag, outSum, outCount} = headData;

endmodule

// File: tb/tb_pcoeff_result_collector.sv
// Self-checking bench for pcoeff_result_collector (TAG_WIDTH=2, GRAB_LATENCY=8).
// Builds with or without PCOEFF_RESULT_CHECK_EN.
module tb_pcoeff_result_collector;
    import pcoeff_result_collector_pkg::*;

    localparam int GL = 8;
    localparam int TW = 2;
    localparam int SW = PCOEFF_SUM_WIDTH;
    localparam int CW = PCOEFF_COUNT_WIDTH;
    localparam int EW = TW + SW + CW;

    logic            clk = 1'b0;
    logic            rst;
    logic            resultsAvailable;
    logic            grabResults;
    logic [SW-1:0]   pcoeffSum;
    logic [CW-1:0]   pcoeffCount;
    logic            outValid;
    logic            outReady;
    logic [TW-1:0]   outTag;
    logic [SW-1:0]   outSum;
    logic [CW-1:0]   outCount;
    logic [1:0]      occupancy;
    collectorState_t dbgState;
`ifdef PCOEFF_RESULT_CHECK_EN
    logic            resultError;
`endif

    pcoeff_result_collector #(
        .SUM_WIDTH    (SW),
        .COUNT_WIDTH  (CW),
        .GRAB_LATENCY (GL),
        .TAG_WIDTH    (TW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .resultsAvailable (resultsAvailable),
        .grabResults      (grabResults),
        .pcoeffSum        (pcoeffSum),
        .pcoeffCount      (pcoeffCount),
        .outValid         (outValid),
        .outReady         (outReady),
        .outTag           (outTag),
        .outSum           (outSum),
        .outCount         (outCount),
        .occupancy        (occupancy),
`ifdef PCOEFF_RESULT_CHECK_EN
        .resultError      (resultError),
`endif
        .dbgState         (dbgState)
    );

    // clock / reset
    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;
    int grabCount = 0;

    logic [EW-1:0]    exp_q[$];
    logic [SW+CW-1:0] pack_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        nChecks++;
        if (act !== req) begin
            nFails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic queueResult(input logic [SW-1:0] s, input logic [CW-1:0] c, input logic [TW-1:0] t,
                               input bit expectOut);
        pack_q.push_back({s, c});
        if (expectOut) exp_q.push_back({t, s, c});
    endtask

    task automatic pulseRa();
        resultsAvailable = 1'b1;
        tick();
        resultsAvailable = 1'b0;
    endtask

    task automatic waitValid(input int budget);
        int n = 0;
        while (outValid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check("valid_timeout", 64'(outValid), 64'd1);
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (!(occupancy == 2'd0 && dbgState == IDLE && exp_q.size() == 0) && n < budget) begin
            tick();
            n++;
        end
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [SW+CW-1:0] garbage();
        logic [95:0] g;
        g = {$urandom, $urandom, $urandom};
        return g[SW+CW-1:0];
    endfunction

    // Pack model: result valid only in the cycle whose closing edge is the capture edge.
    initial begin
        logic [SW+CW-1:0] pv;
        {pcoeffSum, pcoeffCount} = garbage();
        forever begin
            tick();
            if (grabResults === 1'b1) begin
                pv = (pack_q.size() != 0) ? pack_q.pop_front() : garbage();
                repeat (GL - 1) tick();
                {pcoeffSum, pcoeffCount} = pv;
                tick();
                {pcoeffSum, pcoeffCount} = garbage();
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b1 && grabResults === 1'b1) grabCount++;
    end

    // scoreboard: every accepted head must match the oldest expected entry
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst === 1'b1 && outValid === 1'b1 && outReady === 1'b1) begin
            check("pop_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pop_tag",   64'(outTag),   64'(e[EW-1 -: TW]));
                check("pop_sum",   64'(outSum),   64'(e[CW +: SW]));
                check("pop_count", 64'(outCount), 64'(e[CW-1:0]));
            end
        end
    end

    typedef struct {
        logic [SW-1:0] sum;
        logic [CW-1:0] count;
        logic [TW-1:0] expTag;
        logic [SW-1:0] expSum;
        logic [CW-1:0] expCount;
        logic          expErr;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int base;

        tbl[0] = '{SW'(1234), CW'(56), 2'd0, SW'(1234), CW'(56), 1'b0};
        tbl[1] = '{SW'(10),   CW'(3),  2'd1, SW'(10),   CW'(3),  1'b0};
        tbl[2] = '{SW'(0),    CW'(0),  2'd2, SW'(0),    CW'(0),  1'b0};
        tbl[3] = '{'1,        '1,      2'd3, '1,        '1,      1'b0};
        tbl[4] = '{SW'(7),    CW'(7),  2'd0, SW'(7),    CW'(7),  1'b0};

        rst = 1'b0;
        resultsAvailable = 1'b0;
        outReady = 1'b0;
        repeat (3) tick();
        check("rst_grab",  64'(grabResults), 64'd0);
        check("rst_valid", 64'(outValid),    64'd0);
        check("rst_tag",   64'(outTag),      64'd0);
        check("rst_sum",   64'(outSum),      64'd0);
        check("rst_count", 64'(outCount),    64'd0);
        check("rst_occ",   64'(occupancy),   64'd0);
        check("rst_state", 64'(dbgState),    64'(IDLE));
`ifdef PCOEFF_RESULT_CHECK_EN
        check("rst_err",   64'(resultError), 64'd0);
`endif
        rst = 1'b1;
        tick();

        // single results with full latency checks; tags wrap 0,1,2,3,0
        for (int i = 0; i < 5; i++) begin
            queueResult(tbl[i].sum, tbl[i].count, tbl[i].expTag, 1'b0);
            exp_q.push_back({tbl[i].expTag, tbl[i].expSum, tbl[i].expCount});
            outReady = 1'b1;
            pulseRa();
            check("grab_pulse", 64'(grabResults), 64'd1);
            tick();
            check("grab_single", 64'(grabResults), 64'd0);
            repeat (GL - 2) tick();
            check("valid_not_early", 64'(outValid), 64'd0);
            tick();
            check("valid_on_time", 64'(outValid), 64'd1);
            check("vec_tag",   64'(outTag),   64'(tbl[i].expTag));
            check("vec_sum",   64'(outSum),   64'(tbl[i].expSum));
            check("vec_count", 64'(outCount), 64'(tbl[i].expCount));
`ifdef PCOEFF_RESULT_CHECK_EN
            check("vec_err",   64'(resultError), 64'(tbl[i].expErr));
`endif
            tick();
            check("vec_drained", 64'(occupancy), 64'd0);
        end

        // backpressure: only two grabs while outReady is low; third grab on first pop
        outReady = 1'b0;
        base = grabCount;
        queueResult(SW'(100), CW'(1), 2'd1, 1'b1);
        queueResult(SW'(101), CW'(2), 2'd2, 1'b1);
        queueResult(SW'(102), CW'(3), 2'd3, 1'b1);
        resultsAvailable = 1'b1;
        repeat (30) tick();
        check("bp_two_grabs", 64'(grabCount - base), 64'd2);
        check("bp_occ_full",  64'(occupancy), 64'd2);
        check("bp_head_tag",  64'(outTag),    64'd1);
        check("bp_head_sum",  64'(outSum),    64'd100);
        check("bp_idle",      64'(dbgState),  64'(IDLE));
        outReady = 1'b1;
        tick();
        resultsAvailable = 1'b0;
        check("bp_grab_on_pop", 64'(grabResults), 64'd1);
        check("bp_occ_after_pop", 64'(occupancy), 64'd1);
        waitDrain(40);
        check("bp_three_grabs", 64'(grabCount - base), 64'd3);

        // push and pop in the same cycle at occupancy 1
        outReady = 1'b0;
        queueResult(SW'(500), CW'(5), 2'd0, 1'b1);
        queueResult(SW'(600), CW'(6), 2'd1, 1'b1);
        pulseRa();
        waitValid(20);
        pulseRa();
        check("pp_grab", 64'(grabResults), 64'd1);
        repeat (GL - 1) tick();
        check("pp_occ_before", 64'(occupancy), 64'd1);
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        check("pp_occ_same", 64'(occupancy), 64'd1);
        check("pp_head_tag", 64'(outTag),    64'd1);
        check("pp_head_sum", 64'(outSum),    64'd600);
        outReady = 1'b1;
        waitDrain(20);

        // async reset in the middle of a wait discards everything
        outReady = 1'b0;
        queueResult(SW'(700), CW'(7), 2'd2, 1'b0);
        queueResult(SW'(800), CW'(8), 2'd3, 1'b0);
        pulseRa();
        waitValid(20);
        pulseRa();
        check("mid_wait_state", 64'(dbgState), 64'(WAIT));
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check("arst_grab",  64'(grabResults), 64'd0);
        check("arst_valid", 64'(outValid),    64'd0);
        check("arst_occ",   64'(occupancy),   64'd0);
        check("arst_tag",   64'(outTag),      64'd0);
        check("arst_sum",   64'(outSum),      64'd0);
        check("arst_count", 64'(outCount),    64'd0);
        check("arst_state", 64'(dbgState),    64'(IDLE));
        repeat (2) tick();
        rst = 1'b1;
        repeat (GL) tick();
        check("arst_no_stale", 64'(outValid), 64'd0);
        outReady = 1'b1;
        queueResult(SW'(900), CW'(9), 2'd0, 1'b1);
        pulseRa();
        waitValid(20);
        check("arst_first_tag", 64'(outTag), 64'd0);
        check("arst_first_sum", 64'(outSum), 64'd900);
        waitDrain(10);

`ifdef PCOEFF_RESULT_CHECK_EN
        // consistency check: count 0 with nonzero sum, then sum below count
        queueResult(SW'(5), CW'(0), 2'd1, 1'b1);
        pulseRa();
        repeat (GL - 1) tick();
        check("err_not_early", 64'(resultError), 64'd0);
        tick();
        check("err_set", 64'(resultError), 64'd1);
        repeat (5) tick();
        check("err_sticky", 64'(resultError), 64'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("err_cleared", 64'(resultError), 64'd0);
        queueResult(SW'(3), CW'(10), 2'd0, 1'b1);
        pulseRa();
        repeat (GL) tick();
        check("err_sum_lt_count", 64'(resultError), 64'd1);
        waitDrain(10);
`endif

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=expired required=finished");
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails + 1);
        $fatal(1, "timeout");
    end

endmodule
